// File: rtl/fnd_scan_driver.sv
// rtl/fnd_scan_driver.sv - 4-digit packed-BCD scan driver for a common 7-segment module
// Optional per-slot anti-ghosting dead time is enabled by defining FND_DEADTIME_EN.
module fnd_scan_driver #(
  parameter int SCAN_DIV    = 100000,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_en,
  input  logic [15:0] i_value,
  input  logic        i_blank_lz,
  output logic [3:0]  o_value,
  output logic [3:0]  o_digit,
  output logic        o_frame
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] TC = PW'(SCAN_DIV - 1);
`ifdef FND_DEADTIME_EN
  localparam bit DEAD_EN = 1'b1;
`else
  localparam bit DEAD_EN = 1'b0;
`endif

  typedef enum logic {ST_IDLE, ST_SCAN} state_t;

  state_t        state, state_nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic [1:0]    idx, idx_nxt;
  logic [15:0]   shadow, shadow_nxt;
  logic [3:0]    value_nxt, digit_nxt, nib;
  logic          frame_nxt, blank, dead, lit;

  // Outputs are derived from the post-edge state so value and select never skew.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state   <= ST_IDLE;
      presc   <= '0;
      idx     <= 2'd0;
      shadow  <= 16'h0000;
      o_value <= 4'hf;
      o_digit <= 4'b1111;
      o_frame <= 1'b0;
    end else begin
      state   <= state_nxt;
      presc   <= presc_nxt;
      idx     <= idx_nxt;
      shadow  <= shadow_nxt;
      o_value <= value_nxt;
      o_digit <= digit_nxt;
      o_frame <= frame_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    presc_nxt  = presc;
    idx_nxt    = idx;
    shadow_nxt = shadow;
    if (!i_en) begin
      state_nxt  = ST_IDLE;
      presc_nxt  = '0;
      idx_nxt    = 2'd0;
      shadow_nxt = i_value;
    end else if (state == ST_IDLE) begin
      // First enabled edge opens the digit0 slot with a fresh snapshot.
      state_nxt  = ST_SCAN;
      presc_nxt  = '0;
      idx_nxt    = 2'd0;
      shadow_nxt = i_value;
    end else if (presc == TC) begin
      presc_nxt = '0;
      idx_nxt   = idx + 2'd1;
      if (idx == 2'd3) shadow_nxt = i_value;
    end else begin
      presc_nxt = presc + 1'b1;
    end
  end

  always_comb begin
    nib   = 4'h0;
    blank = 1'b0;
    case (idx_nxt)
      2'd0: nib = shadow_nxt[3:0];
      2'd1: begin nib = shadow_nxt[7:4];   blank = (shadow_nxt[15:4]  == 12'h000); end
      2'd2: begin nib = shadow_nxt[11:8];  blank = (shadow_nxt[15:8]  == 8'h00);   end
      default: begin nib = shadow_nxt[15:12]; blank = (shadow_nxt[15:12] == 4'h0); end
    endcase
    dead      = DEAD_EN && (presc_nxt < PW'(DEAD_CYCLES));
    lit       = (state_nxt == ST_SCAN) && !(i_blank_lz && blank) && !dead;
    digit_nxt = 4'b1111;
    if (lit) digit_nxt[idx_nxt] = 1'b0;
    value_nxt = lit ? nib : 4'hf;
    frame_nxt = (state_nxt == ST_SCAN) && (idx_nxt == 2'd0) && (presc_nxt == '0);
  end

endmodule

// File: tb/tb_fnd_scan_driver.sv
// tb/tb_fnd_scan_driver.sv - directed self-checking bench for fnd_scan_driver (SCAN_DIV=4)
// Expectations follow FND_DEADTIME_EN (DEAD_CYCLES=1) when that macro is defined.
module tb_fnd_scan_driver;

`ifdef FND_DEADTIME_EN
  localparam bit DT = 1'b1;
`else
  localparam bit DT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n, en, blank_lz;
  logic [15:0] val;
  logic [3:0]  o_value, o_digit;
  logic        o_frame;
  int          checks = 0;
  int          errors = 0;

  fnd_scan_driver #(.SCAN_DIV(4), .DEAD_CYCLES(1)) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_en       (en),
    .i_value    (val),
    .i_blank_lz (blank_lz),
    .o_value    (o_value),
    .o_digit    (o_digit),
    .o_frame    (o_frame)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_off(input string tag);
    check({tag, "_digit"}, {12'h0, o_digit}, 16'h000f);
    check({tag, "_value"}, {12'h0, o_value}, 16'h000f);
    check({tag, "_frame"}, {15'h0, o_frame}, 16'h0000);
  endtask

  // Walks ncyc cycles from the first cycle of a digit0 slot; slot s shows nibble s of nib when lit[s].
  task automatic run_slots(input logic [15:0] nib, input logic [3:0] lit, input int ncyc,
                           input int chg_at, input logic [15:0] chg_val);
    int s, c;
    logic on;
    logic [3:0] ed, ev;
    for (int n = 0; n < ncyc; n++) begin
      s  = (n / 4) % 4;
      c  = n % 4;
      on = lit[s] && !(DT && c == 0);
      ed = 4'hf;
      if (on) ed[s] = 1'b0;
      ev = on ? nib[4*s +: 4] : 4'hf;
      check("scan_digit", {12'h0, o_digit}, {12'h0, ed});
      check("scan_value", {12'h0, o_value}, {12'h0, ev});
      check("scan_frame", {15'h0, o_frame}, {15'h0, (s == 0 && c == 0)});
      if (n == chg_at) val = chg_val;
      step();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; en = 1'b0; blank_lz = 1'b0; val = 16'h0000;
    step(); step();
    check_off("reset");
    rst_n = 1'b1;
    step();
    check_off("idle");

    // basic scan over two frames
    val = 16'h1234; en = 1'b1;
    step();
    run_slots(16'h1234, 4'hf, 32, -1, 16'h0);

    // leading-zero blanking
    en = 1'b0; step(); check_off("dis1");
    blank_lz = 1'b1; val = 16'h0050; en = 1'b1; step();
    run_slots(16'h0050, 4'b0011, 16, -1, 16'h0);
    en = 1'b0; step(); check_off("dis2");
    val = 16'h0000; en = 1'b1; step();
    run_slots(16'h0000, 4'b0001, 16, -1, 16'h0);

    // frame coherence: change during digit1 slot
    en = 1'b0; blank_lz = 1'b0; val = 16'h1234; step();
    en = 1'b1; step();
    run_slots(16'h1234, 4'hf, 16, 5, 16'h5678);
    run_slots(16'h5678, 4'hf, 16, -1, 16'h0);

    // enable drop in digit2 slot, restart with latest value
    run_slots(16'h5678, 4'hf, 10, -1, 16'h0);
    en = 1'b0; step(); check_off("en_drop");
    val = 16'h9876; step(); check_off("en_low");
    en = 1'b1; step();
    run_slots(16'h9876, 4'hf, 16, -1, 16'h0);

    // asynchronous reset mid-scan
    run_slots(16'h9876, 4'hf, 5, -1, 16'h0);
    #2 rst_n = 1'b0;
    #1 check_off("async_rst");
    val = 16'h4321;
    #3 rst_n = 1'b1;
    step();
    run_slots(16'h4321, 4'hf, 16, -1, 16'h0);

    // disable coinciding with terminal count
    run_slots(16'h4321, 4'hf, 3, -1, 16'h0);
    en = 1'b0; step(); check_off("tc_dis");
    en = 1'b1; step();
    run_slots(16'h4321, 4'hf, 4, -1, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fnd_scan_driver.md
Name: fnd_scan_driver

Overview:
- Time-multiplexes a 4-digit packed-BCD value onto a common 7-segment (FND) module.
- Each cycle it presents one digit nibble on o_value, which feeds the BCD-to-FND font decoder directly, plus the matching active-low digit select.
- Sits between the up-counter/BCD datapath and the font decoder.
- Adds frame-coherent sampling, leading-zero blanking and an enable gate.

Parameters:
- SCAN_DIV, 100000: clock cycles per digit slot (1 kHz/digit at 100 MHz). Legal range is 2 and above.
- DEAD_CYCLES, 1000: blanking cycles at the start of each slot, used only with FND_DEADTIME_EN. Legal range is 1 to SCAN_DIV-1.

Ports:
- i_clk  in  1  system clock, all logic on rising edge
- i_reset_n  in  1  asynchronous active-low reset
- i_en  in  1  scan enable; low turns all digits off
- i_value  in  16  packed BCD; [3:0]=digit0 (rightmost), [15:12]=digit3
- i_blank_lz  in  1  leading-zero blanking enable
- o_value  out  4  nibble to font decoder; 4'hf = blank code
- o_digit  out  4  active-low digit selects, o_digit[0]=digit0
- o_frame  out  1  one-cycle pulse on first cycle of each digit0 slot

Behaviour:
- Interface: one clock, i_clk. Reset i_reset_n is asynchronous, active-low.
- Reset (async, immediate): prescaler=0, index=0, shadow=16'h0000, o_digit=4'b1111, o_value=4'hf, o_frame=0.
- All outputs are registered. o_value and o_digit change on the same edge, with no skew.
- Prescaler counts 0..SCAN_DIV-1 while enabled. At terminal count the index advances 0->1->2->3->0.
- Each digit k is selected (o_digit[k]=0) for exactly SCAN_DIV consecutive cycles, unless it is blanked.
- Shadow register:
  - Loads i_value on the edge where index wraps 3->0.
  - Also loads i_value on every edge while i_en=0.
  - o_value is always taken from the shadow, never directly from i_value.
  - A mid-frame change of i_value therefore never mixes two values within one frame.
- Leading-zero blanking (i_blank_lz=1):
  - Digit k (k=1..3) is blanked if shadow digits k..3 are all 4'h0.
  - Digit0 is never blanked.
  - A blanked slot keeps full SCAN_DIV timing, with o_digit=4'b1111 and o_value=4'hf.
- Non-BCD nibbles (a..f) pass through unmodified. The decoder maps them.
- i_en=0:
  - Next edge: o_digit=4'b1111, o_value=4'hf, o_frame=0.
  - Prescaler and index are held at 0.
- Rising i_en: the first edge sampling i_en=1 starts the digit0 slot and o_frame=1 for that one cycle.
- o_frame timing: high exactly on the first cycle of each digit0 slot, so the period is 4*SCAN_DIV cycles.
- Reset mid-scan: outputs clear immediately. After release, behaviour is as for a rising i_en.
- Simultaneous i_en fall and terminal count: the disable wins, and index returns to 0.

Optional Feature:
- Macro: FND_DEADTIME_EN.
- Defined: for the first DEAD_CYCLES cycles of every slot, o_digit=4'b1111 and o_value=4'hf, which suppresses ghosting. The digit is driven for the remaining SCAN_DIV-DEAD_CYCLES cycles. Slot length and o_frame timing are unchanged; o_frame still marks cycle 0 of the digit0 slot.
- Undefined: no dead time. DEAD_CYCLES is ignored.

Test Plan:
- Reset: assert i_reset_n=0 mid-scan -> o_digit=4'b1111, o_value=4'hf, o_frame=0 without waiting for a clock edge.
- Basic scan (SCAN_DIV=4): i_value=16'h1234, i_en=1, i_blank_lz=0 -> repeating slots of 4 cycles each: (1110,4), (1101,3), (1011,2), (0111,1). o_frame pulses every 16 cycles on the first (1110,4) cycle.
- Blanking: i_value=16'h0050, i_blank_lz=1 -> digit3 and digit2 slots show 1111/f, digit1 shows 5, digit0 shows 0. i_value=16'h0000 -> only the digit0 slot is lit, with value 0.
- Frame coherence: switch i_value from 16'h1234 to 16'h5678 during the digit1 slot -> that frame shows 3, 2, 1 for digits 1..3, and the next frame shows 8, 7, 6, 5.
- Enable: drop i_en during the digit2 slot -> next edge gives 1111/f. Raise i_en -> the digit0 slot starts immediately, with an o_frame pulse and the latest i_value.
- FND_DEADTIME_EN, SCAN_DIV=4, DEAD_CYCLES=1 -> each slot is 1 cycle of 1111/f followed by 3 cycles driving the digit. o_frame still falls on cycle 0 of the digit0 slot.
